// File: rtl/lvds_tx_framer_if.sv
// FIFO-side bundle of the LVDS transmit framer: show-ahead head word, empty flag,
// pop strobe and the read clock handed back to the FIFO.
interface lvds_tx_framer_if #(
    parameter int WORD_W = 32
);
    logic              i_fifo_empty;
    logic [WORD_W-1:0] i_fifo_data;
    logic              o_fifo_pull;
    logic              o_fifo_read_clk;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_data,
        output o_fifo_pull,
        output o_fifo_read_clk
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_data,
        input  o_fifo_pull,
        input  o_fifo_read_clk
    );
endinterface

// File: rtl/lvds_tx_framer.sv
// LVDS DDR transmit framer: serialises FIFO words MSB-first, LANES bits per clock,
// with idle fill, sync-word insertion and a saturating underflow counter.
module lvds_tx_framer #(
    parameter int                WORD_W      = 32,
    parameter int                LANES       = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD   = 32'h0000_0000,
    parameter logic [WORD_W-1:0] SYNC_WORD   = 32'h8000_0000,
    parameter int                SYNC_PERIOD = 0
) (
    input  logic              i_ddr_clk,
    input  logic              i_rst_b,
    input  logic              i_en,
    input  logic              i_sync_input,
    input  logic              i_clear_cnt,
    lvds_tx_framer_if.master  fifo,
    output logic [LANES-1:0]  o_ddr_data,
    output logic              o_word_start,
    output logic [15:0]       o_underflow_cnt,
    output logic [1:0]        o_debug_state
);
    localparam int SLOTS = WORD_W / LANES;
    localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_DATA  = 2'b10,
        ST_UNDER = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [LANES-1:0]  ddr_q, ddr_d;
    logic              ws_q, ws_d;
    logic [15:0]       ucnt_q, ucnt_d;
    logic              sync_q, sync_d;
    logic [15:0]       per_q, per_d;

    logic              boundary_s;
    logic              period_hit_s;
    logic              sync_pend_s;
    logic              ucnt_inc_s;
    logic [WORD_W-1:0] word_s;

    // The phase counter free-runs from reset so word framing never slips.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= ST_IDLE;
            phase_q <= LAST_SLOT;
            shift_q <= IDLE_WORD;
            ddr_q   <= {LANES{1'b0}};
            ws_q    <= 1'b0;
            ucnt_q  <= 16'h0000;
            sync_q  <= 1'b0;
            per_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            ddr_q   <= ddr_d;
            ws_q    <= ws_d;
            ucnt_q  <= ucnt_d;
            sync_q  <= sync_d;
            per_q   <= per_d;
        end
    end

    // Word selection at the boundary slot, shifting on every other slot.
    always_comb begin
        boundary_s   = (phase_q == LAST_SLOT);
        period_hit_s = (SYNC_PERIOD > 0) && (per_q >= 16'(SYNC_PERIOD));
        sync_pend_s  = sync_q || period_hit_s;
        state_d      = state_q;
        per_d        = per_q;
        sync_d       = sync_q || i_sync_input;
        ucnt_inc_s   = 1'b0;
        word_s       = IDLE_WORD;
        phase_d      = phase_q + PW'(1);
        ddr_d        = shift_q[WORD_W-1 -: LANES];
        shift_d      = shift_q << LANES;
        ws_d         = 1'b0;

        if (boundary_s) begin
            phase_d = {PW{1'b0}};
            if (!i_en) begin
                word_s  = IDLE_WORD;
                state_d = ST_IDLE;
            end else if (sync_pend_s) begin
                word_s  = SYNC_WORD;
                state_d = ST_SYNC;
                // A pulse landing in this very cycle survives for the next boundary.
                sync_d  = i_sync_input;
                per_d   = 16'h0000;
            end else if (!fifo.i_fifo_empty) begin
                word_s  = fifo.i_fifo_data;
                state_d = ST_DATA;
                if (per_q != 16'hFFFF) begin
                    per_d = per_q + 16'h0001;
                end else begin
                    per_d = per_q;
                end
            end else begin
                word_s     = IDLE_WORD;
                state_d    = ST_UNDER;
                ucnt_inc_s = 1'b1;
            end
            ddr_d   = word_s[WORD_W-1 -: LANES];
            shift_d = word_s << LANES;
            ws_d    = 1'b1;
        end else begin
            phase_d = phase_q + PW'(1);
        end

        if (i_clear_cnt) begin
            ucnt_d = 16'h0000;
        end else if (ucnt_inc_s && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'h0001;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Pop on the same edge that loads the data word; never while held in reset.
    assign fifo.o_fifo_pull     = i_rst_b && boundary_s && i_en
                                  && !fifo.i_fifo_empty && !sync_pend_s;
    assign fifo.o_fifo_read_clk = i_ddr_clk;

    assign o_ddr_data      = ddr_q;
    assign o_word_start    = ws_q;
    assign o_underflow_cnt = ucnt_q;
    assign o_debug_state   = state_q;
endmodule
